// File: rtl/shift_pkg.sv
// Shared types and default widths for the shift sequencer and the barrel shifter it feeds.
package shift_pkg;

    localparam int unsigned SHIFT_N = 64;
    localparam int unsigned SHIFT_M = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command and beat-stream signals between the sequencer and its parent/shifter.
interface shift_sequencer_if
    import shift_pkg::*;
#(
    parameter int N = SHIFT_N,
    parameter int M = SHIFT_M
);

    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_data;
    logic [M-1:0] cmd_start;
    logic [M-1:0] cmd_step;
    logic [M:0]   cmd_count;
    logic [N-1:0] input_bits;
    logic [M-1:0] shift_pattern;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    // master: command source and beat sink; slave: the sequencer itself
    modport master (
        output cmd_valid, cmd_data, cmd_start, cmd_step, cmd_count, out_ready,
        input  cmd_ready, input_bits, shift_pattern, out_valid, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_start, cmd_step, cmd_count, out_ready,
        output cmd_ready, input_bits, shift_pattern, out_valid, busy, done
    );

endinterface

// File: rtl/shift_sequencer.sv
// Accepts one shift command and streams (data, amount) beats to the barrel shifter,
// stepping the amount modulo 2^M, then pulses done.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int N = SHIFT_N,
    parameter int M = SHIFT_M
) (
    input logic              clk,
    input logic              rst_n,
    shift_sequencer_if.slave bus
);

    localparam logic [M:0] REM_ONE = {{M{1'b0}}, 1'b1};

    seq_state_t   state_q, state_d;
    logic [N-1:0] input_bits_q, input_bits_d;
    logic [M-1:0] shift_pattern_q, shift_pattern_d;
    logic [M-1:0] step_q, step_d;
    logic [M:0]   remaining_q, remaining_d;
    logic         out_valid_q, out_valid_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         cmd_ready_q, cmd_ready_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a signal unassigned (no latches).
        state_d         = state_q;
        input_bits_d    = input_bits_q;
        shift_pattern_d = shift_pattern_q;
        step_d          = step_q;
        remaining_d     = remaining_q;
        out_valid_d     = out_valid_q;
        done_d          = 1'b0;
        busy_d          = busy_q;
        cmd_ready_d     = cmd_ready_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    input_bits_d    = bus.cmd_data;
                    shift_pattern_d = bus.cmd_start;
                    step_d          = bus.cmd_step;
                    remaining_d     = bus.cmd_count;
                    busy_d          = 1'b1;
                    cmd_ready_d     = 1'b0;
                    if (bus.cmd_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = RUN;
                        out_valid_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_valid_q && bus.out_ready) begin
                    // Sum truncates to M bits: the amount wraps rather than saturates.
                    shift_pattern_d = shift_pattern_q + step_q;
                    remaining_d     = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // NOTE: registers are all small control/datapath flops, so each gets an explicit reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            input_bits_q    <= '0;
            shift_pattern_q <= '0;
            step_q          <= '0;
            remaining_q     <= '0;
            out_valid_q     <= 1'b0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            cmd_ready_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q         <= state_d;
            input_bits_q    <= input_bits_d;
            shift_pattern_q <= shift_pattern_d;
            step_q          <= step_d;
            remaining_q     <= remaining_d;
            out_valid_q     <= out_valid_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            cmd_ready_q     <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.input_bits    = input_bits_q;
    assign bus.shift_pattern = shift_pattern_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: table vectors, corner sequences, random commands.
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int N = 64;
    localparam int M = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_sequencer_if #(.N(N), .M(M)) bus();

    shift_sequencer #(.N(N), .M(M)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // mode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random ready
    typedef struct {
        logic [N-1:0] data;
        int           start;
        int           step;
        int           count;
        int           mode;
        int           exp_first;
        int           exp_last;
    } vec_t;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Amount of beat k: start + k*step, wrapped modulo 2^M.
    function automatic int model_pat(input int start, input int step, input int k);
        return (start + k * step) % (1 << M);
    endfunction

    function automatic bit ready_at(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 3) == 1;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Present the command and wait (bounded) for the accepting edge; returns at #1 after it.
    task automatic issue(input vec_t v);
        bit ok = 1'b0;
        bus.cmd_data  = v.data;
        bus.cmd_start = v.start[M-1:0];
        bus.cmd_step  = v.step[M-1:0];
        bus.cmd_count = v.count[M:0];
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    // Follow one command from the cycle after acceptance to the IDLE cycle after done.
    task automatic monitor(input vec_t v, output int first, output int last);
        int           c         = 1;
        int           beats     = 0;
        int           last_hs   = 0;
        bit           seen_done = 1'b0;
        bit           stalled   = 1'b0;
        logic [M-1:0] held_pat  = '0;
        first = -1;
        last  = -1;
        while (c <= 3000 && !seen_done) begin
            bus.out_ready = ready_at(v.mode, c);
            check("cmd_ready_while_busy", bus.cmd_ready, 0);
            check("busy_while_busy", bus.busy, 1);
            if (stalled) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_pattern", bus.shift_pattern, held_pat);
            end
            if (bus.done) begin
                seen_done = 1'b1;
                check("done_out_valid", bus.out_valid, 0);
                check("done_cycle", c, last_hs + 1);
                check("beat_count", beats, v.count);
            end else if (bus.out_valid) begin
                check("input_bits", bus.input_bits, v.data);
                check("pattern", bus.shift_pattern, model_pat(v.start, v.step, beats));
                if (v.mode == 0) check("beat_cycle", c, beats + 1);
                stalled  = !bus.out_ready;
                held_pat = bus.shift_pattern;
                if (bus.out_ready) begin
                    if (beats == 0) first = int'(bus.shift_pattern);
                    last    = int'(bus.shift_pattern);
                    beats++;
                    last_hs = c;
                end
            end else begin
                check("valid_or_done", 0, 1);
            end
            if (!seen_done) begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        if (!seen_done) begin
            check("done_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            check("ready_after_done", bus.cmd_ready, 1);
            check("done_single_pulse", bus.done, 0);
            check("busy_after_done", bus.busy, 0);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int first, last;
        issue(v);
        monitor(v, first, last);
        check({tag, "_first"}, first, v.exp_first);
        check({tag, "_last"}, last, v.exp_last);
    endtask

    vec_t vecs[7];
    vec_t va, vb, vr;

    initial begin
        vecs[0] = '{64'd7,                  0,  1, 16, 0,  0, 15};
        vecs[1] = '{64'hDEAD_BEEF_0123_4567, 62, 3,  3, 0, 62,  4};
        vecs[2] = '{64'hA5A5_A5A5_5A5A_5A5A,  5, 10, 4, 1,  5, 35};
        vecs[3] = '{64'h1234,               20,  7,  0, 0, -1, -1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF,  0, 1, 64, 0,  0, 63};
        vecs[5] = '{64'h55,                  9,  0,  5, 1,  9,  9};
        vecs[6] = '{64'h0F0F_0000_F0F0_FFFF,  3, 5, 64, 2,  3, 62};

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_start = '0;
        bus.cmd_step  = '0;
        bus.cmd_count = '0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_input_bits", bus.input_bits, 0);
        check("rst_pattern", bus.shift_pattern, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // A second command held during RUN must wait for IDLE and not disturb the first.
        va = '{64'hAAAA_AAAA, 1, 2, 5, 0, 1, 9};
        vb = '{64'hBBBB_BBBB, 40, 30, 2, 0, 40, 6};
        begin
            int first, last;
            issue(va);
            bus.cmd_data  = vb.data;
            bus.cmd_start = vb.start[M-1:0];
            bus.cmd_step  = vb.step[M-1:0];
            bus.cmd_count = vb.count[M:0];
            bus.cmd_valid = 1'b1;
            monitor(va, first, last);
            check("held_a_first", first, va.exp_first);
            check("held_a_last", last, va.exp_last);
        end
        run_vec("held_b", vb);

        // Reset after the second of eight beats aborts without a done pulse.
        bus.out_ready = 1'b1;
        issue('{64'hC0FFEE, 11, 1, 8, 0, 11, 18});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_pattern", bus.shift_pattern, 0);
        check("abort_input_bits", bus.input_bits, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_abort_done", bus.done, 0);
            check("post_abort_valid", bus.out_valid, 0);
            check("post_abort_ready", bus.cmd_ready, 1);
        end
        run_vec("post_abort", '{64'h77, 33, 2, 3, 0, 33, 37});

        for (int i = 0; i < 30; i++) begin
            vr.data      = {$urandom(), $urandom()};
            vr.start     = int'($urandom_range(0, 63));
            vr.step      = int'($urandom_range(0, 63));
            vr.count     = int'($urandom_range(0, 64));
            vr.mode      = int'($urandom_range(0, 2));
            vr.exp_first = (vr.count == 0) ? -1 : model_pat(vr.start, vr.step, 0);
            vr.exp_last  = (vr.count == 0) ? -1 : model_pat(vr.start, vr.step, vr.count - 1);
            run_vec($sformatf("rand%0d", i), vr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
